// File: rtl/sc_dispatch_if.sv
// Bundle of job, engine and completion signals between the dispatcher and its environment.
// The slave modport is the dispatcher's view; master is the environment's.
interface sc_dispatch_if #(
  parameter int NUM_ENGINES  = 4,
  parameter int DATA_WIDTH   = 1024,
  parameter int RETURN_WIDTH = 41,
  parameter int EW           = $clog2(NUM_ENGINES)
);
  logic                                dispatch_en;
  logic                                job_valid;
  logic                                job_ready;
  logic [DATA_WIDTH-1:0]               job_data;
  logic [NUM_ENGINES-1:0]              eng_start;
  logic [NUM_ENGINES-1:0]              eng_ready;
  logic [DATA_WIDTH-1:0]               eng_data;
  logic [NUM_ENGINES-1:0]              eng_cmpl_ready;
  logic [NUM_ENGINES-1:0]              eng_cmpl_accept;
  logic [NUM_ENGINES*RETURN_WIDTH-1:0] eng_cmpl_data;
  logic                                cmpl_valid;
  logic                                cmpl_ready;
  logic [RETURN_WIDTH-1:0]             cmpl_data;
  logic [EW-1:0]                       cmpl_engine;
  logic [NUM_ENGINES-1:0]              busy_mask;
  logic                                idle;

  modport master (
    output dispatch_en, job_valid, job_data, eng_ready, eng_cmpl_ready,
           eng_cmpl_data, cmpl_ready,
    input  job_ready, eng_start, eng_data, eng_cmpl_accept, cmpl_valid,
           cmpl_data, cmpl_engine, busy_mask, idle
  );

  modport slave (
    input  dispatch_en, job_valid, job_data, eng_ready, eng_cmpl_ready,
           eng_cmpl_data, cmpl_ready,
    output job_ready, eng_start, eng_data, eng_cmpl_accept, cmpl_valid,
           cmpl_data, cmpl_engine, busy_mask, idle
  );
endinterface

// File: rtl/sc_dispatch.sv
// Round-robin dispatch of jobs to NUM_ENGINES sort engines and round-robin merge of their completions.
// Latency: job accept -> eng_start 2 cycles, eng_cmpl_ready -> cmpl_valid 1 cycle; job_ready low while a job is held, completion held until cmpl_ready.
module sc_dispatch #(
  parameter int NUM_ENGINES  = 4,
  parameter int DATA_WIDTH   = 1024,
  parameter int RETURN_WIDTH = 41,
  parameter int EW           = $clog2(NUM_ENGINES)
) (
  input logic        clk,
  input logic        rst,
  sc_dispatch_if.slave io
);

  typedef enum logic {D_IDLE, D_ARB}  d_state_t;
  typedef enum logic {C_IDLE, C_HOLD} c_state_t;

  d_state_t d_state, d_state_nxt;
  c_state_t c_state, c_state_nxt;

  logic [DATA_WIDTH-1:0]   job_reg;
  logic [NUM_ENGINES-1:0]  busy_q;
  logic [NUM_ENGINES-1:0]  start_q;
  logic [NUM_ENGINES-1:0]  accept_q;
  logic [EW-1:0]           d_ptr;
  logic [EW-1:0]           c_ptr;
  logic [RETURN_WIDTH-1:0] cmpl_data_q;
  logic [EW-1:0]           cmpl_engine_q;

  logic [EW:0]             d_pick;
  logic [EW:0]             c_pick;
  logic [EW-1:0]           d_idx;
  logic [EW-1:0]           c_idx;
  logic                    d_grant;
  logic                    c_grant;
  logic                    job_take;
  logic [NUM_ENGINES-1:0]  d_onehot;
  logic [NUM_ENGINES-1:0]  c_onehot;

  // Returns {found, index} of the first request at or after ptr, wrapping.
  function automatic logic [EW:0] rr_pick(input logic [NUM_ENGINES-1:0] req,
                                          input logic [EW-1:0] ptr);
    logic          found;
    logic [EW-1:0] idx;
    logic [EW-1:0] pick;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      idx = ptr + EW'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return {found, pick};
  endfunction

  always_comb begin
    d_pick   = rr_pick(io.eng_ready & ~busy_q, d_ptr);
    c_pick   = rr_pick(io.eng_cmpl_ready & busy_q, c_ptr);
    d_idx    = d_pick[EW-1:0];
    c_idx    = c_pick[EW-1:0];
    d_grant  = (d_state == D_ARB) && io.dispatch_en && d_pick[EW];
    c_grant  = (c_state == C_IDLE) && c_pick[EW];
    job_take = (d_state == D_IDLE) && io.job_valid;
    d_onehot = '0;
    c_onehot = '0;
    if (d_grant) d_onehot[d_idx] = 1'b1;
    if (c_grant) c_onehot[c_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_state <= D_IDLE;
      c_state <= C_IDLE;
    end else begin
      d_state <= d_state_nxt;
      c_state <= c_state_nxt;
    end
  end

  always_comb begin
    d_state_nxt = d_state;
    c_state_nxt = c_state;
    case (d_state)
      D_IDLE:  if (io.job_valid) d_state_nxt = D_ARB;
      D_ARB:   if (d_grant)      d_state_nxt = D_IDLE;
      default: d_state_nxt = D_IDLE;
    endcase
    case (c_state)
      C_IDLE:  if (c_grant)       c_state_nxt = C_HOLD;
      C_HOLD:  if (io.cmpl_ready) c_state_nxt = C_IDLE;
      default: c_state_nxt = C_IDLE;
    endcase
  end

  // Control outputs are forced to their reset values for the whole reset cycle.
  always_comb begin
    io.job_ready       = !rst && (d_state == D_IDLE);
    io.cmpl_valid      = !rst && (c_state == C_HOLD);
    io.eng_start       = rst ? '0 : start_q;
    io.eng_cmpl_accept = rst ? '0 : accept_q;
    io.busy_mask       = rst ? '0 : busy_q;
    io.idle            = rst || ((d_state == D_IDLE) && (busy_q == '0) && (c_state == C_IDLE));
    io.eng_data        = job_reg;
    io.cmpl_data       = cmpl_data_q;
    io.cmpl_engine     = cmpl_engine_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      job_reg       <= '0;
      busy_q        <= '0;
      start_q       <= '0;
      accept_q      <= '0;
      d_ptr         <= '0;
      c_ptr         <= '0;
      cmpl_data_q   <= '0;
      cmpl_engine_q <= '0;
    end else begin
      if (job_take) job_reg <= io.job_data;
      start_q  <= d_onehot;
      accept_q <= c_onehot;
      // Dispatch only sets idle engines and completion only clears busy ones, so the two never collide.
      busy_q   <= (busy_q & ~c_onehot) | d_onehot;
      if (d_grant) d_ptr <= d_idx + EW'(1);
      if (c_grant) begin
        c_ptr         <= c_idx + EW'(1);
        cmpl_data_q   <= io.eng_cmpl_data[int'(c_idx)*RETURN_WIDTH +: RETURN_WIDTH];
        cmpl_engine_q <= c_idx;
      end
    end
  end

endmodule

// File: tb/tb_sc_dispatch.sv
// Randomized and directed bench for sc_dispatch against a transaction-level reference model.
module tb_sc_dispatch;
  localparam int N  = 4;
  localparam int DW = 1024;
  localparam int RW = 41;
  localparam int EW = 2;
  localparam logic [RW-1:0] K1 = 41'h0AA_1234_5678;
  localparam logic [RW-1:0] K3 = 41'h155_8765_4321;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  sc_dispatch_if #(.NUM_ENGINES(N), .DATA_WIDTH(DW), .RETURN_WIDTH(RW), .EW(EW)) io ();

  sc_dispatch #(.NUM_ENGINES(N), .DATA_WIDTH(DW), .RETURN_WIDTH(RW), .EW(EW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (low 128 bits) t=%0t", name, act[127:0], exp[127:0], $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd_job();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [N*RW-1:0] rnd_cmpl();
    logic [N*RW-1:0] v;
    for (int i = 0; i < N*RW; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // Reference model: one held job, a set of busy engines, two rotating pointers,
  // and one pending completion; predicts the outputs of the following cycle.
  bit            started = 0;
  bit            m_hold;
  logic [DW-1:0] m_job;
  logic [DW-1:0] m_start_data;
  logic [N-1:0]  m_busy;
  int            m_dptr, m_cptr;
  bit            m_pend;
  logic [RW-1:0] m_rec;
  int            m_ceng;
  int            m_start, m_acc;

  always @(negedge clk) begin
    logic [N-1:0] es, ea, b;
    int ns, na, idx;
    if (started) begin
      if (rst) begin
        chk("rst_job_ready", io.job_ready, 0);
        chk("rst_eng_start", io.eng_start, 0);
        chk("rst_cmpl_accept", io.eng_cmpl_accept, 0);
        chk("rst_cmpl_valid", io.cmpl_valid, 0);
        chk("rst_busy_mask", io.busy_mask, 0);
        chk("rst_idle", io.idle, 1);
      end else begin
        es = '0;
        ea = '0;
        if (m_start >= 0) es[m_start] = 1'b1;
        if (m_acc >= 0) ea[m_acc] = 1'b1;
        chk("job_ready", io.job_ready, !m_hold);
        chk("eng_start", io.eng_start, es);
        chk("eng_cmpl_accept", io.eng_cmpl_accept, ea);
        chk("cmpl_valid", io.cmpl_valid, m_pend);
        chk("busy_mask", io.busy_mask, m_busy);
        chk("idle", io.idle, !m_hold && m_busy == '0 && !m_pend);
        if (m_start >= 0) chk("eng_data", io.eng_data, m_start_data);
        if (m_pend) begin
          chk("cmpl_data", io.cmpl_data, m_rec);
          chk("cmpl_engine", io.cmpl_engine, m_ceng);
        end
      end
    end
    if (rst) begin
      started = 1;
      m_hold = 0; m_busy = '0; m_dptr = 0; m_cptr = 0;
      m_pend = 0; m_start = -1; m_acc = -1;
    end else begin
      b  = m_busy;
      ns = -1;
      na = -1;
      if (!m_hold) begin
        if (io.job_valid) begin
          m_hold = 1;
          m_job  = io.job_data;
        end
      end else if (io.dispatch_en) begin
        for (int i = 0; i < N; i++) begin
          idx = (m_dptr + i) % N;
          if (ns < 0 && io.eng_ready[idx] && !b[idx]) ns = idx;
        end
      end
      if (ns >= 0) begin
        m_hold = 0;
        m_dptr = (ns + 1) % N;
        m_start_data = m_job;
        m_busy[ns] = 1'b1;
      end
      if (!m_pend) begin
        for (int i = 0; i < N; i++) begin
          idx = (m_cptr + i) % N;
          if (na < 0 && io.eng_cmpl_ready[idx] && b[idx]) na = idx;
        end
        if (na >= 0) begin
          m_pend = 1;
          m_rec  = io.eng_cmpl_data[na*RW +: RW];
          m_ceng = na;
          m_cptr = (na + 1) % N;
          m_busy[na] = 1'b0;
        end
      end else if (io.cmpl_ready) begin
        m_pend = 0;
      end
      m_start = ns;
      m_acc   = na;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    io.job_valid      = 1'b0;
    io.eng_cmpl_ready = '0;
    tick();
    rst = 1'b0;
  endtask

  // Drives one job for one cycle, then runs n further cycles; returns start pulses seen.
  task automatic one_job(input int n, output int first_cyc, output logic [N-1:0] first_val);
    first_cyc = -1;
    first_val = '0;
    io.job_valid = 1'b1;
    io.job_data  = rnd_job();
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      if (first_cyc < 0 && io.eng_start != '0) begin
        first_cyc = k;
        first_val = io.eng_start;
      end
      tick();
      io.job_valid = 1'b0;
    end
  endtask

  initial begin
    int             order[$];
    int             cengs[$];
    logic [RW-1:0]  cdats[$];
    int             fc, acc_cnt, vld_cnt;
    logic [N-1:0]   fv;
    logic [RW-1:0]  held_d;
    logic [EW-1:0]  held_e;
    bit             stable;
    logic [N*RW-1:0] cv;

    rst = 1'b1;
    io.dispatch_en = 1'b1; io.job_valid = 1'b0; io.job_data = '0;
    io.eng_ready = '0; io.eng_cmpl_ready = '0; io.eng_cmpl_data = '0; io.cmpl_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("reset_job_ready", io.job_ready, 0);
    chk("reset_idle", io.idle, 1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("first_job_ready", io.job_ready, 1);
    chk("first_busy", io.busy_mask, 0);
    tick();

    // Four back-to-back jobs to four ready engines, then a fifth stuck in arbitration.
    io.eng_ready = '1;
    io.job_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      io.job_data = rnd_job();
      @(negedge clk);
      for (int i = 0; i < N; i++) if (io.eng_start[i]) order.push_back(i);
      tick();
    end
    @(negedge clk);
    chk("s1_start_count", order.size(), 4);
    for (int i = 0; i < order.size() && i < 4; i++) chk("s1_start_order", order[i], i);
    chk("s1_busy_all", io.busy_mask, 4'hF);
    chk("s1_job5_held", io.job_ready, 0);
    tick();

    // Single eligible engine 2 from pointer 0, then pointer must sit at 3.
    do_reset();
    io.eng_ready = 4'b0100;
    one_job(5, fc, fv);
    chk("s2_start_cycle", fc, 2);
    chk("s2_start_val", fv, 4'b0100);
    io.eng_ready = '1;
    one_job(4, fc, fv);
    chk("s2_dptr_next", fv, 4'b1000);

    // Engines 1 and 3 complete together: 1 first, then 3.
    do_reset();
    io.eng_ready = 4'b0010;
    one_job(4, fc, fv);
    io.eng_ready = 4'b1000;
    one_job(4, fc, fv);
    @(negedge clk);
    chk("s3_busy_13", io.busy_mask, 4'b1010);
    tick();
    io.eng_ready = '0;
    cv = rnd_cmpl();
    cv[1*RW +: RW] = K1;
    cv[3*RW +: RW] = K3;
    io.eng_cmpl_data  = cv;
    io.eng_cmpl_ready = 4'b1010;
    io.cmpl_ready     = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (io.cmpl_valid) begin
        cengs.push_back(int'(io.cmpl_engine));
        cdats.push_back(io.cmpl_data);
      end
      tick();
    end
    chk("s3_cmpl_count", cengs.size(), 2);
    if (cengs.size() == 2) begin
      chk("s3_first_eng", cengs[0], 1);
      chk("s3_first_data", cdats[0], K1);
      chk("s3_second_eng", cengs[1], 3);
      chk("s3_second_data", cdats[1], K3);
    end
    @(negedge clk);
    chk("s3_busy_clear", io.busy_mask, 0);
    chk("s3_idle", io.idle, 1);
    tick();

    // Completion held against cmpl_ready=0.
    do_reset();
    io.eng_cmpl_ready = '0;
    io.eng_ready = 4'b0001;
    one_job(4, fc, fv);
    io.cmpl_ready = 1'b0;
    io.eng_cmpl_ready = 4'b0001;
    io.eng_cmpl_data = rnd_cmpl();
    acc_cnt = 0; vld_cnt = 0; stable = 1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      acc_cnt += $countones(io.eng_cmpl_accept);
      if (io.cmpl_valid) begin
        if (vld_cnt == 0) begin
          held_d = io.cmpl_data;
          held_e = io.cmpl_engine;
        end else if (io.cmpl_data !== held_d || io.cmpl_engine !== held_e) begin
          stable = 0;
        end
        vld_cnt++;
      end
      tick();
      io.eng_cmpl_data = rnd_cmpl();
    end
    chk("s4_accept_pulses", acc_cnt, 1);
    chk("s4_valid_cycles", vld_cnt, 6);
    chk("s4_stable", stable, 1);
    io.cmpl_ready = 1'b1;
    io.eng_cmpl_ready = '0;
    tick();
    @(negedge clk);
    chk("s4_released", io.cmpl_valid, 0);
    tick();

    // dispatch_en gating.
    do_reset();
    io.dispatch_en = 1'b0;
    io.eng_ready = '1;
    one_job(6, fc, fv);
    chk("s5_no_start", fc, -1);
    @(negedge clk);
    chk("s5_held", io.job_ready, 0);
    tick();
    io.dispatch_en = 1'b1;
    fc = -1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (fc < 0 && io.eng_start != '0) begin fc = k; fv = io.eng_start; end
      tick();
    end
    chk("s5_start_after_en", fc >= 0, 1);
    chk("s5_start_val", fv, 4'b0001);

    // Reset with a job held in arbitration and a completion pending.
    do_reset();
    io.eng_ready = 4'b0001;
    one_job(4, fc, fv);
    io.eng_ready = '0;
    io.cmpl_ready = 1'b0;
    io.eng_cmpl_ready = 4'b0001;
    io.eng_cmpl_data = rnd_cmpl();
    io.job_valid = 1'b1;
    io.job_data = rnd_job();
    @(negedge clk);
    tick();
    io.job_valid = 1'b0;
    @(negedge clk);
    chk("s6_pre_cmpl_valid", io.cmpl_valid, 1);
    chk("s6_pre_job_held", io.job_ready, 0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("s6_rst_start", io.eng_start, 0);
    chk("s6_rst_accept", io.eng_cmpl_accept, 0);
    tick();
    rst = 1'b0;
    io.eng_ready = '1;
    @(negedge clk);
    chk("s6_after_start", io.eng_start, 0);
    chk("s6_after_accept", io.eng_cmpl_accept, 0);
    chk("s6_after_valid", io.cmpl_valid, 0);
    chk("s6_after_busy", io.busy_mask, 0);
    chk("s6_after_idle", io.idle, 1);
    chk("s6_after_cdata", io.cmpl_data, 0);
    chk("s6_after_ceng", io.cmpl_engine, 0);
    chk("s6_after_edata", io.eng_data, 0);
    tick();
    @(negedge clk);
    chk("s6_dropped_job", io.eng_start, 0);
    tick();
    io.cmpl_ready = 1'b1;

    // Randomized traffic, including occasional resets and stray completion requests.
    for (int k = 0; k < 4000; k++) begin
      rst               = ($urandom_range(0, 299) == 0);
      io.dispatch_en    = ($urandom_range(0, 7) != 0);
      io.job_valid      = 1'($urandom_range(0, 1));
      io.job_data       = rnd_job();
      io.eng_ready      = N'($urandom);
      io.eng_cmpl_ready = N'($urandom);
      io.eng_cmpl_data  = rnd_cmpl();
      io.cmpl_ready     = ($urandom_range(0, 2) != 0);
      tick();
    end
    rst = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sc_dispatch.md
SC_DISPATCH -- requirements
Module: sc_dispatch

Interface
REQ-001 SHALL have parameter NUM_ENGINES, default 4, number of sort engines shared (power of two, 2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 1024, job descriptor width.
REQ-003 SHALL have parameter RETURN_WIDTH, default 41, completion record width.
REQ-004 SHALL have parameter EW, default log2(NUM_ENGINES), engine index width.
REQ-005 SHALL use one clock and a synchronous active-high reset, with ports as follows:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active high.
- dispatch_en  in  1  1 = new dispatches allowed.
- job_valid  in  1  descriptor offered.
- job_ready  out  1  descriptor accepted when job_valid & job_ready.
- job_data  in  DATA_WIDTH  descriptor.
- eng_start  out  NUM_ENGINES  one-hot start pulse per engine.
- eng_ready  in  NUM_ENGINES  engine can take a job.
- eng_data  out  DATA_WIDTH  descriptor broadcast to all engines.
- eng_cmpl_ready  in  NUM_ENGINES  engine holds a completion.
- eng_cmpl_accept  out  NUM_ENGINES  one-hot completion pop pulse.
- eng_cmpl_data  in  NUM_ENGINES*RETURN_WIDTH  completion records, engine i at slice i.
- cmpl_valid  out  1  merged completion valid.
- cmpl_ready  in  1  downstream accepts.
- cmpl_data  out  RETURN_WIDTH  merged completion record.
- cmpl_engine  out  EW  source engine of cmpl_data.
- busy_mask  out  NUM_ENGINES  engines holding an outstanding job.
- idle  out  1  no job held, busy_mask==0, cmpl_valid==0.

Function
REQ-006 Dispatch FSM SHALL have states D_IDLE, D_ARB; job_ready = (state==D_IDLE).
REQ-007 D_IDLE: on job_valid, job_data SHALL be captured into job_reg and the FSM SHALL move to D_ARB.
REQ-008 Eligible set SHALL be eng_ready & ~busy_mask; D_ARB with dispatch_en=1 and a non-empty eligible set SHALL grant the first eligible index at or after d_ptr (modulo NUM_ENGINES).
REQ-009 Grant at cycle T SHALL produce eng_start[g]=1 for exactly cycle T+1, and the FSM SHALL be in D_IDLE at T+1.
REQ-010 eng_data SHALL equal job_reg and SHALL be stable during the eng_start cycle.
REQ-011 busy_mask[g] SHALL set in the eng_start cycle; d_ptr SHALL become (g+1) mod NUM_ENGINES.
REQ-012 D_ARB SHALL hold job_reg indefinitely while dispatch_en=0 or the eligible set is empty, with job_ready=0.
REQ-013 Completion FSM SHALL have states C_IDLE, C_HOLD.
REQ-014 C_IDLE: candidates SHALL be eng_cmpl_ready & busy_mask; non-busy eng_cmpl_ready SHALL be ignored.
REQ-015 C_IDLE: the grant SHALL be round-robin from c_ptr; at the grant cycle T:
- eng_cmpl_data slice g is captured.
- At T+1: cmpl_valid=1, cmpl_engine=g, eng_cmpl_accept[g]=1 for that cycle only.
- busy_mask[g] clears at T+1.
- c_ptr becomes g+1.
REQ-016 C_HOLD SHALL hold cmpl_valid, cmpl_data and cmpl_engine stable until cmpl_ready=1, then return to C_IDLE; no re-arbitration occurs in C_HOLD.
REQ-017 Set and clear of busy_mask in the same cycle SHALL be applied independently per bit (set only on non-busy bits, clear only on busy bits).
REQ-018 A job accepted in the eng_start cycle SHALL NOT alter eng_data until the following cycle.
REQ-019 Dispatch latency SHALL be job accept T, earliest eng_start at T+2; completion latency SHALL be eng_cmpl_ready at T, cmpl_valid at T+1.

Reset
REQ-020 While rst=1, the following SHALL be driven/held at reset values:
- Both FSMs in D_IDLE/C_IDLE.
- job_reg, cmpl_data, cmpl_engine, busy_mask = 0.
- d_ptr, c_ptr = 0.
- eng_start, eng_cmpl_accept, cmpl_valid = 0.
- job_ready = 0.
- idle = 1.
REQ-021 Reset mid-operation SHALL drop any held job and any held completion without issuing eng_start or eng_cmpl_accept.
REQ-022 job_ready SHALL first assert in the cycle after rst deasserts.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- All eng_ready=1, 4 back-to-back jobs -> eng_start order 0,1,2,3; busy_mask=4'hF; job 5 held in D_ARB with job_ready=0.
- eng_ready=4'b0100, d_ptr=0, one job -> eng_start=4'b0100 two cycles after accept; d_ptr=3.
- Engines 1 and 3 busy, both eng_cmpl_ready=1, c_ptr=0, cmpl_ready=1 -> engine 1 returned first, then engine 3; busy_mask=0; idle=1.
- cmpl_ready=0 for 5 cycles -> cmpl_data/cmpl_engine stable; exactly one eng_cmpl_accept pulse.
- dispatch_en=0 with job held -> no eng_start; after dispatch_en=1 -> eng_start within 2 cycles.
- rst during D_ARB with a job held and cmpl_valid=1 -> next cycle all outputs at reset values, busy_mask=0, no start or accept pulse.
